mr_job_gate: RTL and testbench
==============================

# mr_job_gate

Job-framing stage directly upstream of the map/reduce engine. Admits exactly one host-programmed job length of 64-bit stream words into the engine, then blocks the stream and waits a fixed drain period for the mapper/reducer pipeline to settle. It then reports the job's word count (final reduced count minus the count sampled at job start) and holds it until the host acknowledges. The data bus is not routed through this block; only valid/ready are gated.

## Interface
- DRAIN_CYCLES, 16: cycles waited after the last accepted word before sampling the reduced count; must be ≥ 1 and ≥ the mapper+reducer latency.
- TIMEOUT_CYCLES, 65536: idle-beat limit in RUN; used only when the timeout feature is compiled in.
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_job_start  in  1  single-cycle start pulse.
- i_job_len  in  32  job length in 64-bit words; sampled on an accepted start.
- i_result_ack  in  1  host acknowledge; releases DONE.
- i_strm_data_valid  in  1  upstream (PCIe) stream valid.
- o_strm_data_rdy  out  1  ready returned to upstream.
- o_mr_valid  out  1  valid forwarded to the engine.
- i_mr_rdy  in  1  engine ready.
- i_data_count  in  32  engine's reduced count, cumulative since reset.
- o_busy  out  1  high in RUN and DRAIN.
- o_done  out  1  high in DONE.
- o_intr  out  1  one-cycle pulse on entry to DONE.
- o_result  out  32  job result.
- o_words_seen  out  32  beats accepted in the current or last job.
- o_err  out  1  sticky: start requested outside IDLE.
- o_timeout  out  1  last job ended by watchdog; tied 0 when the feature is compiled out.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE. All registered outputs are 0 after reset.
- Beat = o_mr_valid & i_mr_rdy.
- Gating is combinational:
  - o_mr_valid = i_strm_data_valid & (state==RUN).
  - o_strm_data_rdy = i_mr_rdy & (state==RUN).
- IDLE + i_job_start:
  - Capture len and baseline = i_data_count.
  - Clear o_words_seen, o_timeout and o_result.
  - Next state is DRAIN if len==0, else RUN.
- RUN:
  - Each beat increments o_words_seen.
  - A beat with o_words_seen == len−1 → DRAIN.
- DRAIN:
  - Down-counter loaded with DRAIN_CYCLES−1 on entry.
  - When it reaches 0: o_result ← i_data_count − baseline, computed modulo 2^32 (wrap-around is legal). State → DONE.
- DONE:
  - o_done=1; o_intr=1 for the first DONE cycle only.
  - i_result_ack → IDLE. o_result and o_words_seen hold until the next accepted start.
- i_job_start in RUN, DRAIN or DONE is ignored and sets o_err. o_err is cleared only by i_rst.
- i_result_ack outside DONE is ignored.
- Same-cycle ack and start in DONE: the ack is taken, the start is ignored and sets o_err.
- i_rst asserted mid-job → IDLE on the next edge; all outputs are 0 from that edge on.

## Timing
- Start sampled at edge 0 → o_busy=1 and gating open from cycle 1.
- The last beat occurs in RUN at cycle t. Gating closes from t+1. DRAIN occupies t+1 … t+DRAIN_CYCLES.
- o_done, o_intr and the valid o_result appear at cycle t+DRAIN_CYCLES+1.
- len==0: start at edge 0 → DRAIN cycles 1 … DRAIN_CYCLES → DONE at DRAIN_CYCLES+1.
- Ack sampled in DONE → IDLE next cycle. A new start is accepted one cycle after that at the earliest.

## Configuration
- MR_JOB_TIMEOUT_EN defined:
  - In RUN, a counter clears on every beat and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, the block goes to DRAIN and sets o_timeout=1.
  - The result is computed normally; o_words_seen shows the partial count.
- MR_JOB_TIMEOUT_EN undefined: RUN waits indefinitely; o_timeout is tied 0; no watchdog logic.

## Structure
- Package mr_pkg: the state enum (IDLE/RUN/DRAIN/DONE), COUNT_W=32, and localparams derived for counter widths.
- Sub-module mr_down_counter: loadable down-counter with a zero flag. One instance for drain; a second, compiled only under the macro, for the watchdog.

## Test plan
- len=4, valid and engine-ready held high, baseline 100 ramping to 107 → 4 beats, 5th word refused (o_strm_data_rdy=0), o_result=7, o_words_seen=4, single o_intr pulse at t+DRAIN_CYCLES+1.
- len=3, i_mr_rdy toggling every cycle → exactly 3 beats, none dropped or duplicated, DONE timing is relative to the 3rd beat.
- len=0, i_data_count constant at 55 → no beats, DONE at cycle DRAIN_CYCLES+1, o_result=0.
- Baseline 0xFFFF_FFF0, final count 0x0000_0010 → o_result=0x0000_0020.
- Start pulse during RUN → o_err=1, len unchanged. i_rst mid-RUN → next cycle IDLE, all outputs 0, o_err cleared.
- MR_JOB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, len=10, valid stops after 2 beats → after 8 idle cycles enter DRAIN, then DONE with o_timeout=1 and o_words_seen=2.

Source files
------------

// File: rtl/mr_pkg.sv
// Shared types and constants for the map/reduce job gate.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mr_pkg;

    localparam int COUNT_W            = 32;
    localparam int DRAIN_CYCLES_DEF   = 16;
    localparam int TIMEOUT_CYCLES_DEF = 65536;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed for a down-counter that is loaded with n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mr_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
// Latency: load and decrement take effect at the next clock edge; zero flag is combinational from the count.
// Backpressure: none; decrement is simply held off while dec is low.
// Ports: clk/rst (sync, active-high); load + load_val (load wins over dec); dec; zero.
module mr_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mr_job_gate.sv
// Admits one host-programmed job of stream words into the map/reduce engine, drains, then reports the word count.
// Latency: gating opens the cycle after start; result/done/intr appear DRAIN_CYCLES+1 cycles after the last beat.
// Backpressure: valid/ready pass straight through (combinational) while running and are forced low otherwise.
// Ports: i_clk/i_rst (sync, active-high); i_job_start/i_job_len/i_result_ack host control;
//        i_strm_data_valid/o_strm_data_rdy upstream; o_mr_valid/i_mr_rdy engine; i_data_count engine count;
//        o_busy/o_done/o_intr/o_result/o_words_seen/o_err/o_timeout status.
// Optional: define MR_JOB_TIMEOUT_EN to add an idle-beat watchdog in RUN (o_timeout otherwise tied 0).
module mr_job_gate
    import mr_pkg::*;
#(
    parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_job_start,
    input  logic [COUNT_W-1:0] i_job_len,
    input  logic               i_result_ack,
    input  logic               i_strm_data_valid,
    output logic               o_strm_data_rdy,
    output logic               o_mr_valid,
    input  logic               i_mr_rdy,
    input  logic [COUNT_W-1:0] i_data_count,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_intr,
    output logic [COUNT_W-1:0] o_result,
    output logic [COUNT_W-1:0] o_words_seen,
    output logic               o_err,
    output logic               o_timeout
);

    localparam int DRAIN_W = cnt_w(DRAIN_CYCLES);

    if (DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mr_job_gate: DRAIN_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_t             state, state_d;
    logic [COUNT_W-1:0] len, baseline, words_seen, result;
    logic               err, intr;
    logic               in_run, beat, last_beat;
    logic               start_acc, drain_load, finish, drain_zero;
`ifdef MR_JOB_TIMEOUT_EN
    logic               wd_zero, wd_expire;
`endif

    assign in_run    = (state == RUN);
    assign beat      = i_strm_data_valid & i_mr_rdy & in_run;
    assign last_beat = beat && (words_seen == len - CNT_ONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        start_acc  = 1'b0;
        drain_load = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (i_job_start) begin
                    start_acc = 1'b1;
                    // A zero-length job skips RUN but still drains, so the
                    // result is taken against a settled engine count.
                    if (i_job_len == '0) begin
                        state_d    = DRAIN;
                        drain_load = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end
`ifdef MR_JOB_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (drain_zero) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                if (i_result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loaded with DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES cycles.
    mr_down_counter #(.W(DRAIN_W)) u_drain (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (drain_load),
        .load_val (DRAIN_W'(DRAIN_CYCLES - 1)),
        .dec      (state == DRAIN),
        .zero     (drain_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len        <= '0;
            baseline   <= '0;
            words_seen <= '0;
            result     <= '0;
            err        <= 1'b0;
            intr       <= 1'b0;
        end else begin
            intr <= finish;
            if (start_acc) begin
                len        <= i_job_len;
                baseline   <= i_data_count;
                words_seen <= '0;
                result     <= '0;
            end else if (beat) begin
                words_seen <= words_seen + CNT_ONE;
            end
            // Engine count is cumulative and may wrap; modular subtraction
            // still yields the job's own contribution.
            if (finish) begin
                result <= i_data_count - baseline;
            end
            if (i_job_start && (state != IDLE)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef MR_JOB_TIMEOUT_EN
    localparam int WD_W = cnt_w(TIMEOUT_CYCLES);

    logic timeout;

    // Reloaded on start and on every beat; fires on the TIMEOUT_CYCLES-th
    // consecutive idle RUN cycle.
    mr_down_counter #(.W(WD_W)) u_watchdog (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (start_acc | beat),
        .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .dec      (in_run & ~beat),
        .zero     (wd_zero)
    );

    assign wd_expire = in_run & ~beat & wd_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timeout <= 1'b0;
        end else if (start_acc) begin
            timeout <= 1'b0;
        end else if (wd_expire) begin
            timeout <= 1'b1;
        end
    end

    assign o_timeout = timeout;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_mr_valid      = i_strm_data_valid & in_run;
    assign o_strm_data_rdy = i_mr_rdy & in_run;
    assign o_busy          = (state == RUN) || (state == DRAIN);
    assign o_done          = (state == DONE);
    assign o_intr          = intr;
    assign o_result        = result;
    assign o_words_seen    = words_seen;
    assign o_err           = err;

endmodule

// File: tb/tb_mr_job_gate.sv
// Scoreboard bench for mr_job_gate: job drivers push expected results, a negedge monitor checks them on o_intr.
module tb_mr_job_gate;

    localparam int D = 6;
    localparam int T = 8;

    logic        i_clk, i_rst, i_job_start, i_result_ack;
    logic [31:0] i_job_len, i_data_count;
    logic        i_strm_data_valid, i_mr_rdy;
    logic        o_strm_data_rdy, o_mr_valid, o_busy, o_done, o_intr, o_err, o_timeout;
    logic [31:0] o_result, o_words_seen;

    mr_job_gate #(.DRAIN_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_job_start       (i_job_start),
        .i_job_len         (i_job_len),
        .i_result_ack      (i_result_ack),
        .i_strm_data_valid (i_strm_data_valid),
        .o_strm_data_rdy   (o_strm_data_rdy),
        .o_mr_valid        (o_mr_valid),
        .i_mr_rdy          (i_mr_rdy),
        .i_data_count      (i_data_count),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_intr            (o_intr),
        .o_result          (o_result),
        .o_words_seen      (o_words_seen),
        .o_err             (o_err),
        .o_timeout         (o_timeout)
    );

    typedef struct {
        logic [31:0] result;
        logic [31:0] words;
        logic        to;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    bit   err_exp = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: every o_intr pulse must match the oldest outstanding job.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && o_intr) begin
            if (exp_q.size() == 0) begin
                chk("intr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", o_result, e.result);
                chk("words_seen", o_words_seen, e.words);
                chk("timeout_flag", 32'(o_timeout), 32'(e.to));
                chk("done_with_intr", 32'(o_done), 32'd1);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Runs one job end to end. The model tracks beats from its own stimulus:
    // the job ends on the len-th beat or, with the watchdog, on the T-th idle cycle.
    task automatic run_job(input logic [31:0] len, input bit toggle_rdy, input int valid_stop,
                           input logic [31:0] base, input logic [31:0] fin, input int glitch_k,
                           input bit start_with_ack, input bit exp_to);
        int n, idle, k, last, w;
        bit v, r, ended;
        n = 0; idle = 0; k = 0; last = 0; ended = 0;
        step();
        i_job_len = len; i_data_count = base; i_job_start = 1'b1;
        i_strm_data_valid = 1'b1; i_mr_rdy = 1'b1;
        @(negedge i_clk);
        chk("idle_gate_closed", 32'({o_mr_valid, o_strm_data_rdy}), 32'd0);
        last = cyc;
        if (len == 0) ended = 1;
        while (!ended && k < 100) begin
            step();
            k++;
            i_job_start = (k == glitch_k);
            i_job_len   = (k == glitch_k) ? 32'd2 : len;
            if (k == glitch_k) err_exp = 1;
            v = (valid_stop < 0) || (n < valid_stop);
            r = toggle_rdy ? k[0] : 1'b1;
            i_strm_data_valid = v;
            i_mr_rdy          = r;
            i_data_count      = (32'(k) < fin - base) ? base + 32'(k) : fin;
            @(negedge i_clk);
            chk("run_valid", 32'(o_mr_valid), 32'(v));
            chk("run_rdy", 32'(o_strm_data_rdy), 32'(r));
            if (v && r) begin n++; idle = 0; end else idle++;
            if (n == len) ended = 1;
`ifdef MR_JOB_TIMEOUT_EN
            if (idle == T) ended = 1;
`endif
            if (ended) last = cyc;
        end
        if (!ended) chk("run_bound", 32'd0, 32'd1);
        exp_q.push_back('{result: fin - base, words: 32'(n), to: exp_to, cyc: last + D + 1});

        // First DRAIN cycle: upstream offers another word, it must be refused.
        step();
        i_job_start = 1'b0; i_strm_data_valid = 1'b1; i_mr_rdy = 1'b1; i_data_count = fin;
        @(negedge i_clk);
        chk("drain_rdy", 32'(o_strm_data_rdy), 32'd0);
        chk("drain_valid", 32'(o_mr_valid), 32'd0);
        chk("drain_busy", 32'(o_busy), 32'd1);

        w = 0;
        while (o_done !== 1'b1 && w < 100) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 100) chk("done_bound", 32'd0, 32'd1);

        step();
        i_result_ack = 1'b1;
        i_job_start  = start_with_ack;
        if (start_with_ack) err_exp = 1;
        @(negedge i_clk);
        chk("done_hold", 32'(o_done), 32'd1);
        chk("intr_single", 32'(o_intr), 32'd0);
        step();
        i_result_ack = 1'b0; i_job_start = 1'b0; i_strm_data_valid = 1'b0;
        @(negedge i_clk);
        chk("ack_done_low", 32'(o_done), 32'd0);
        chk("ack_busy_low", 32'(o_busy), 32'd0);
        chk("result_hold", o_result, fin - base);
        chk("words_hold", o_words_seen, 32'(n));
        chk("err_state", 32'(o_err), 32'(err_exp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_intr"}, 32'(o_intr), 32'd0);
        chk({tag, "_result"}, o_result, 32'd0);
        chk({tag, "_words"}, o_words_seen, 32'd0);
        chk({tag, "_err"}, 32'(o_err), 32'd0);
        chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
        chk({tag, "_gate"}, 32'({o_mr_valid, o_strm_data_rdy}), 32'd0);
    endtask

    initial begin
        // Reset with a start pulse and open stream offered: must all be ignored.
        i_rst = 1'b1; i_job_start = 1'b1; i_job_len = 32'd3; i_result_ack = 1'b0;
        i_strm_data_valid = 1'b1; i_mr_rdy = 1'b1; i_data_count = 32'd9;
        step(); step();
        @(negedge i_clk);
        chk_all_zero("reset");
        step();
        i_rst = 1'b0; i_job_start = 1'b0; i_strm_data_valid = 1'b0;

        // len=4, everything ready, count 100 -> 107.
        run_job(32'd4, 1'b0, -1, 32'd100, 32'd107, 0, 1'b0, 1'b0);
        // len=3, engine ready toggling every cycle.
        run_job(32'd3, 1'b1, -1, 32'd200, 32'd203, 0, 1'b0, 1'b0);
        // len=0, count constant.
        run_job(32'd0, 1'b0, -1, 32'd55, 32'd55, 0, 1'b0, 1'b0);
        // Start pulse during RUN: ignored, len stays 5, error latched.
        run_job(32'd5, 1'b0, -1, 32'd7, 32'd12, 2, 1'b0, 1'b0);

        // Reset in the middle of RUN clears everything including the error.
        step();
        i_job_len = 32'd8; i_data_count = 32'd0; i_job_start = 1'b1;
        i_strm_data_valid = 1'b1; i_mr_rdy = 1'b1;
        step(); i_job_start = 1'b0;
        step();
        @(negedge i_clk);
        chk("mid_run_busy", 32'(o_busy), 32'd1);
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        err_exp = 0;
        @(negedge i_clk);
        chk_all_zero("mid_rst");
        i_strm_data_valid = 1'b0;

        // Wrapping engine count; a start coinciding with the ack is refused.
        run_job(32'd2, 1'b0, -1, 32'hFFFF_FFF0, 32'h0000_0010, 0, 1'b1, 1'b0);

`ifdef MR_JOB_TIMEOUT_EN
        // Valid stops after 2 beats; watchdog ends the job after T idle cycles.
        run_job(32'd10, 1'b0, 2, 32'd300, 32'd309, 0, 1'b0, 1'b1);
        // A following normal job clears the timeout flag.
        run_job(32'd1, 1'b0, -1, 32'd5, 32'd6, 0, 1'b0, 1'b0);
`endif

        step(); step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
